// File: rtl/tach_quad_counter_pkg.sv
// Shared definitions for the quadrature tach decoder.
//   TACH_CNT_W      default position counter width
//   S00/S01/S11/S10 gray-code states of the {B,A} pins. Walking them in that
//                   order counts up; walking them in reverse counts down.
//   quad_dec()      classifies a prev -> q pin transition as {illegal,valid,up}
package tach_quad_counter_pkg;

  localparam int TACH_CNT_W = 16;

  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S10 = 2'b10;

  // Returns {illegal, valid, up}. A transition is illegal when both pins
  // changed between two samples, because the direction cannot be known.
  function automatic logic [2:0] quad_dec(input logic [1:0] prev, input logic [1:0] q);
    logic [1:0] nxt_up;
    case (prev)
      S00:     nxt_up = S01;
      S01:     nxt_up = S11;
      S11:     nxt_up = S10;
      default: nxt_up = S00;
    endcase
    if (q == prev) begin
      quad_dec = 3'b000;
    end else if ((q ^ prev) == 2'b11) begin
      quad_dec = 3'b100;
    end else if (q == nxt_up) begin
      quad_dec = 3'b011;
    end else begin
      quad_dec = 3'b010;
    end
  endfunction

endpackage

// File: rtl/tach_quad_counter_sync_filter.sv
// Synchroniser and optional glitch filter for the two tach pins.
// Optional feature macro: TACH_GLITCH_FILTER_EN (adds the stability filter).
// Ports:
//   clk     in  system clock
//   resetn  in  synchronous reset, active low
//   tach    in  raw {B,A} pins, asynchronous to clk
//   q       out synchronised (and, with the filter, debounced) {B,A}
module tach_quad_counter_sync_filter
  import tach_quad_counter_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] tach,
  output logic [1:0] q
);

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (FILT_LEN < 1) begin : g_chk_filt
    $error("FILT_LEN must be at least 1");
  end

  logic [1:0] sync_q [SYNC_STAGES];
  logic [1:0] sync_d [SYNC_STAGES];

  always_comb begin
    sync_d[0] = tach;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < SYNC_STAGES; i++) begin
      if (!resetn) sync_q[i] <= S00;
      else         sync_q[i] <= sync_d[i];
    end
  end

`ifdef TACH_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILT_LEN + 1);

  logic [FW-1:0] cnt_q [2];
  logic [FW-1:0] cnt_d [2];
  logic [1:0]    filt_q;
  logic [1:0]    filt_d;
  logic [1:0]    raw;

  assign raw = sync_q[SYNC_STAGES-1];

  // Each bit counts consecutive samples that disagree with the accepted
  // value; any agreeing sample restarts the count, so short pulses vanish.
  always_comb begin
    filt_d = filt_q;
    for (int b = 0; b < 2; b++) begin
      cnt_d[b] = '0;
      if (raw[b] != filt_q[b]) begin
        if (cnt_q[b] == FW'(FILT_LEN - 1)) filt_d[b] = raw[b];
        else                               cnt_d[b] = cnt_q[b] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      filt_q   <= S00;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      filt_q   <= filt_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  assign q = filt_q;
`else
  assign q = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/tach_quad_counter.sv
// Quadrature tach decoder with a wrapping signed position counter and a
// snapshot register so the SPI side can read low then high byte coherently.
// Optional feature macro: TACH_GLITCH_FILTER_EN (input stability filter).
// Ports:
//   clk       in  system clock
//   resetn    in  synchronous reset, active low
//   tach      in  raw {B,A} pins, asynchronous
//   clr       in  1-clk pulse, clears count (wins over a same-cycle step)
//   snap_req  in  1-clk pulse, snap <= count as registered before this edge
//   err_clr   in  1-clk pulse, clears err (a same-cycle illegal step wins)
//   count     out live position count
//   snap      out snapshot of count
//   step      out 1-clk pulse per accepted legal transition
//   dir       out direction of last accepted step, 1 = up
//   err       out sticky illegal-transition flag
//
// primed | meaning
// -------+-----------------------------------------------------------
//   0    | just out of reset; next sample only loads prev, no decode
//   1    | decoding every sample against prev
module tach_quad_counter
  import tach_quad_counter_pkg::*;
#(
  parameter int CNT_WIDTH   = TACH_CNT_W,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [1:0]           tach,
  input  logic                 clr,
  input  logic                 snap_req,
  input  logic                 err_clr,
  output logic [CNT_WIDTH-1:0] count,
  output logic [CNT_WIDTH-1:0] snap,
  output logic                 step,
  output logic                 dir,
  output logic                 err
);

  logic [1:0] q;

  tach_quad_counter_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_sync_filter (
    .clk    (clk),
    .resetn (resetn),
    .tach   (tach),
    .q      (q)
  );

  logic                 primed_q, primed_d;
  logic [1:0]           prev_q, prev_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] snap_q, snap_d;
  logic                 step_q, step_d;
  logic                 dir_q, dir_d;
  logic                 err_q, err_d;
  logic [2:0]           dec;

  assign dec = quad_dec(prev_q, q);

  always_comb begin
    primed_d = 1'b1;
    prev_d   = q;
    count_d  = count_q;
    snap_d   = snap_q;
    step_d   = 1'b0;
    dir_d    = dir_q;
    err_d    = err_q;

    if (err_clr) err_d = 1'b0;

    if (primed_q) begin
      if (dec[2]) begin
        err_d = 1'b1;
      end else if (dec[1] && !clr) begin
        step_d  = 1'b1;
        dir_d   = dec[0];
        count_d = dec[0] ? count_q + 1'b1 : count_q - 1'b1;
      end
    end

    // A step coinciding with clr is dropped; prev still follows q above.
    if (clr) count_d = '0;

    if (snap_req) snap_d = count_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      primed_q <= 1'b0;
      prev_q   <= S00;
      count_q  <= '0;
      snap_q   <= '0;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      primed_q <= primed_d;
      prev_q   <= prev_d;
      count_q  <= count_d;
      snap_q   <= snap_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
    end
  end

  assign count = count_q;
  assign snap  = snap_q;
  assign step  = step_q;
  assign dir   = dir_q;
  assign err   = err_q;

endmodule

// File: tb/tb_tach_quad_counter.sv
// Self-checking bench for tach_quad_counter. The reference model tracks the
// pin position as a phase 0..3 around the gray cycle and counts with plain
// arithmetic on the phase difference (1 = up, 3 = down, 2 = illegal).
module tb_tach_quad_counter;

`ifdef TACH_GLITCH_FILTER_EN
  localparam int LAT = 3 + 4;
`else
  localparam int LAT = 3;
`endif
  localparam int SETTLE = LAT + 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  tach;
  logic        clr, snap_req, err_clr;
  logic [15:0] count, snap;
  logic        step, dir, err;

  tach_quad_counter #(
    .CNT_WIDTH   (16),
    .SYNC_STAGES (2),
    .FILT_LEN    (4)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .tach     (tach),
    .clr      (clr),
    .snap_req (snap_req),
    .err_clr  (err_clr),
    .count    (count),
    .snap     (snap),
    .step     (step),
    .dir      (dir),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int steps_seen = 0;

  always @(negedge clk) if (step === 1'b1) steps_seen++;

  logic [1:0]  gray_of [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int          phase;
  logic [15:0] m_count, m_snap;
  logic        m_dir, m_err;
  int          m_steps = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(m_count));
    chk({tag, ".snap"},  32'(snap),  32'(m_snap));
    chk({tag, ".dir"},   32'(dir),   32'(m_dir));
    chk({tag, ".err"},   32'(err),   32'(m_err));
    chk({tag, ".steps"}, 32'(steps_seen), 32'(m_steps));
  endtask

  task automatic do_reset(input string tag);
    tach   = 2'b00;
    phase  = 0;
    resetn = 1'b0;
    tick;
    tick;
    chk({tag, ".count"}, 32'(count), 32'h0);
    chk({tag, ".snap"},  32'(snap),  32'h0);
    chk({tag, ".step"},  32'(step),  32'h0);
    chk({tag, ".dir"},   32'(dir),   32'h0);
    chk({tag, ".err"},   32'(err),   32'h0);
    m_count = '0;
    m_snap  = '0;
    m_dir   = 1'b0;
    m_err   = 1'b0;
    resetn  = 1'b1;
    repeat (SETTLE) tick;
    check_all({tag, ".post"});
  endtask

  // Moves the pins by delta phase positions and lands the control pulses on
  // exactly the edge where the resulting step reaches the counter.
  task automatic do_move(input int delta, input bit s, input bit c, input bit e,
                         input string tag);
    phase = (phase + delta) & 3;
    tach  = gray_of[phase];
    repeat (LAT - 1) tick;
    snap_req = s;
    clr      = c;
    err_clr  = e;
    tick;
    snap_req = 1'b0;
    clr      = 1'b0;
    err_clr  = 1'b0;

    if (s) m_snap = m_count;
    if (e) m_err = 1'b0;
    if (delta == 2) begin
      m_err = 1'b1;
    end else if (delta != 0 && !c) begin
      m_count = (delta == 1) ? m_count + 16'd1 : m_count - 16'd1;
      m_dir   = (delta == 1);
      m_steps++;
    end
    if (c) m_count = '0;

    repeat (SETTLE - LAT) tick;
    check_all(tag);
  endtask

  initial begin
    resetn   = 1'b0;
    tach     = 2'b00;
    clr      = 1'b0;
    snap_req = 1'b0;
    err_clr  = 1'b0;

    do_reset("rst0");

    do_move(1, 0, 0, 0, "t1_up");
    do_move(0, 1, 0, 0, "t1_snap");

    do_reset("rst1");
    do_move(1, 0, 0, 0, "t2_a");
    do_move(1, 0, 0, 0, "t2_b");
    do_move(3, 0, 0, 0, "t2_c");
    do_move(3, 0, 0, 0, "t2_d");
    do_move(3, 0, 0, 0, "t2_e");
    do_move(0, 1, 0, 0, "t2_snap");
    chk("t2_snap_hi", 32'(snap[15:8]), 32'hFF);

    do_move(1, 0, 0, 0, "t3_wrap");
    do_move(1, 0, 0, 0, "t3_up");
    do_move(1, 0, 1, 0, "t3_clr_step");

    do_move(2, 0, 0, 0, "t4_illegal");
    do_move(2, 0, 0, 1, "t4_errclr_race");
    do_move(0, 0, 0, 1, "t4_errclr");

    do_move(0, 0, 1, 0, "t5_clr");
    do_move(1, 0, 0, 0, "t5_a");
    do_move(1, 0, 0, 0, "t5_b");
    do_move(1, 1, 0, 0, "t5_snap_step");
    do_move(1, 0, 0, 0, "t5_hold");

`ifdef TACH_GLITCH_FILTER_EN
    tach = gray_of[phase] ^ 2'b01;
    tick;
    tick;
    tach = gray_of[phase];
    repeat (SETTLE + 2) tick;
    check_all("t6_glitch");
    do_move(1, 0, 0, 0, "t6_stable");
`endif
    do_move(3, 0, 0, 0, "t6_pre");
    do_reset("t6_rst");
    do_move(3, 0, 0, 0, "t6_after");

    for (int i = 0; i < 150; i++) begin
      int r;
      int d;
      r = int'($urandom_range(0, 15));
      if (r < 6)       d = 1;
      else if (r < 12) d = 3;
      else if (r < 13) d = 2;
      else             d = 0;
      do_move(d, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 3) == 0), "rnd");
      if ($urandom_range(0, 49) == 0) do_reset("rnd_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
